ahfp_cordic_collect: RTL and testbench

- Downstream stage of the floating-point CORDIC rotator. The rotator pipeline is free-running and cannot stall.
- The block tracks each launched sample through the rotator's fixed latency with a tag/valid delay line.
- When the sample emerges, it applies the quadrant sign fix-up to x_cos/y_sin and buffers the result in a small FIFO with a valid/ready output.
- Credit-based admission (in_ready) guarantees no emerging result is ever dropped.

---
 rtl/ahfp_cordic_collect.sv | 154 +++++++++++++++
 tb/tb_ahfp_cordic_collect.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahfp_cordic_collect.sv
// ahfp_cordic_collect: output collector for the free-running floating-point CORDIC rotator.
//
// The block tracks each launched sample through the rotator's fixed latency using a
// tag/valid delay line. When the sample emerges, the quadrant sign fix-up is applied
// to cos/sin and the result is queued in a small FIFO with a valid/ready output.
// Credit-based admission (in_ready) reserves a FIFO slot for every sample in flight,
// so a result leaving the rotator always finds room in the FIFO.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     launch handshake toward the rotator's upstream
//   in_negate, in_tag       per-sample quadrant flag and user tag
//   cordic_cos, cordic_sin  rotator outputs, valid LATENCY cycles after launch
//   out_valid / out_ready   result FIFO handshake
//   out_cos, out_sin        fixed-up results at the FIFO head
//   out_tag                 tag of the FIFO head entry

module ahfp_cordic_collect #(
  parameter int unsigned LATENCY = 12,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_negate,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [31:0]      cordic_cos,
  input  logic [31:0]      cordic_sin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_cos,
  output logic [31:0]      out_sin,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic launch;
  logic capture;
  logic pop;

  // Delay line mirroring the rotator pipeline
  logic [LATENCY-1:0] dl_valid_q;
  logic [LATENCY-1:0] dl_neg_q;
  logic [TAG_W-1:0]   dl_tag_q [LATENCY];

  // Result FIFO
  logic [31:0]      mem_cos_q [DEPTH];
  logic [31:0]      mem_sin_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW:0]    credit_sum;

  logic [31:0] fix_cos;
  logic [31:0] fix_sin;

  // Zero/denormal flushes to +0; otherwise the sign flips when the angle was reduced by pi.
  function automatic logic [31:0] fixup(input logic [31:0] v, input logic neg);
    if (v[30:23] == 8'h00) begin
      return 32'h0000_0000;
    end
    return {v[31] ^ neg, v[30:0]};
  endfunction

  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign in_ready   = credit_sum < (CntW + 1)'(DEPTH);
  assign launch     = in_valid & in_ready;
  assign capture    = dl_valid_q[LATENCY-1];
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;

  assign fix_cos = fixup(cordic_cos, dl_neg_q[LATENCY-1]);
  assign fix_sin = fixup(cordic_sin, dl_neg_q[LATENCY-1]);

  assign out_cos = mem_cos_q[rd_ptr_q];
  assign out_sin = mem_sin_q[rd_ptr_q];
  assign out_tag = mem_tag_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      dl_neg_q   <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        dl_tag_q[i] <= '0;
      end
    end else begin
      for (int i = int'(LATENCY) - 1; i > 0; i--) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_neg_q[i]   <= dl_neg_q[i-1];
        dl_tag_q[i]   <= dl_tag_q[i-1];
      end
      dl_valid_q[0] <= launch;
      dl_neg_q[0]   <= in_negate;
      dl_tag_q[0]   <= in_tag;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({capture, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({launch, capture})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_cos_q[i] <= '0;
        mem_sin_q[i] <= '0;
        mem_tag_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      if (capture) begin
        mem_cos_q[wr_ptr_q] <= fix_cos;
        mem_sin_q[wr_ptr_q] <= fix_sin;
        mem_tag_q[wr_ptr_q] <= dl_tag_q[LATENCY-1];
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Credit scheme invariants
  a_no_capture_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && (count_q == CntW'(DEPTH))));
  a_inflight_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q <= CntW'(DEPTH));

endmodule

// File: tb/tb_ahfp_cordic_collect.sv
// Self-checking bench for ahfp_cordic_collect with a behavioural fixed-latency rotator.
module tb_ahfp_cordic_collect;

  localparam int unsigned LAT = 12;
  localparam int unsigned DEP = 4;
  localparam int unsigned TW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_negate;
  logic [TW-1:0] in_tag;
  logic [31:0]   cordic_cos;
  logic [31:0]   cordic_sin;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_cos;
  logic [31:0]   out_sin;
  logic [TW-1:0] out_tag;

  // Values the rotator will produce for the sample being presented
  logic [31:0] stim_cos;
  logic [31:0] stim_sin;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  ahfp_cordic_collect #(
    .LATENCY(LAT),
    .DEPTH  (DEP),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_negate (in_negate),
    .in_tag    (in_tag),
    .cordic_cos(cordic_cos),
    .cordic_sin(cordic_sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .out_tag   (out_tag)
  );

  // Rotator model: free-running, not reset; idle slots carry a toggling junk value.
  logic [31:0] pipe_cos [LAT];
  logic [31:0] pipe_sin [LAT];
  logic [31:0] junk = 32'h3F00_0001;

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_cos[i] <= pipe_cos[i-1];
      pipe_sin[i] <= pipe_sin[i-1];
    end
    pipe_cos[0] <= (in_valid && in_ready) ? stim_cos : junk;
    pipe_sin[0] <= (in_valid && in_ready) ? stim_sin : ~junk;
    junk        <= junk + 32'h0080_1357;
  end

  assign cordic_cos = pipe_cos[LAT-1];
  assign cordic_sin = pipe_sin[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [TW-1:0] tag;
    logic          neg;
    logic [31:0]   cos_in;
    logic [31:0]   sin_in;
    logic [31:0]   cos_exp;
    logic [31:0]   sin_exp;
  } vec_t;

  typedef struct {
    logic [31:0]   c;
    logic [31:0]   s;
    logic [TW-1:0] t;
  } exp_t;

  vec_t vecs [6];
  exp_t expq [$];
  exp_t mon_e;
  logic mon_en = 1'b0;

  // Scoreboard: compare every popped head against the expected queue.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", 32'd1, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("tbl_cos", out_cos, mon_e.c);
        chk("tbl_sin", out_sin, mon_e.s);
        chk("tbl_tag", 32'(out_tag), 32'(mon_e.t));
      end
    end
  end

  // Hold a launch request until accepted; inputs change 1 ns after a rising edge.
  task automatic launch_one(input logic [TW-1:0] tag, input logic neg,
                            input logic [31:0] c, input logic [31:0] s);
    int waited = 0;
    bit done = 0;
    in_valid  = 1'b1;
    in_tag    = tag;
    in_negate = neg;
    stim_cos  = c;
    stim_sin  = s;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 100) begin
        chk("launch_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
  endtask

  initial begin
    int acc;
    int seen;
    int w;
    logic a;

    vecs[0] = '{4'd1,  1'b0, 32'h3F3504F3, 32'hBF3504F3, 32'h3F3504F3, 32'hBF3504F3};
    vecs[1] = '{4'd2,  1'b1, 32'h3F800000, 32'h00000001, 32'hBF800000, 32'h00000000};
    vecs[2] = '{4'd4,  1'b1, 32'hBF000000, 32'h80000000, 32'h3F000000, 32'h00000000};
    vecs[3] = '{4'd5,  1'b1, 32'h7F800000, 32'h00800000, 32'hFF800000, 32'h80800000};
    vecs[4] = '{4'd9,  1'b0, 32'h807FFFFF, 32'hC0490FDB, 32'h00000000, 32'hC0490FDB};
    vecs[5] = '{4'd15, 1'b1, 32'h007FFFFF, 32'h3DCCCCCD, 32'h00000000, 32'hBDCCCCCD};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_negate = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    stim_cos  = '0;
    stim_sin  = '0;
    #12 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_cos", out_cos, 32'd0);
    chk("rst_out_sin", out_sin, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);

    // Single sample: launch in cycle 0, out_valid rises in cycle LAT+1
    @(posedge clk);
    #1;
    launch_one(4'd3, 1'b0, 32'h3F3504F3, 32'h3F3504F3);
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    chk("single_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_cos", out_cos, 32'h3F3504F3);
    chk("single_sin", out_sin, 32'h3F3504F3);
    chk("single_tag", 32'(out_tag), 32'd3);
    @(negedge clk);
    chk("single_hold_valid", 32'(out_valid), 32'd1);
    chk("single_hold_cos", out_cos, 32'h3F3504F3);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("single_popped", 32'(out_valid), 32'd0);

    // Table vectors streamed with the consumer always ready
    foreach (vecs[i]) expq.push_back('{vecs[i].cos_exp, vecs[i].sin_exp, vecs[i].tag});
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    foreach (vecs[i]) launch_one(vecs[i].tag, vecs[i].neg, vecs[i].cos_in, vecs[i].sin_in);
    in_valid = 1'b0;
    w = 0;
    while (expq.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    chk("tbl_drained", 32'(expq.size()), 32'd0);
    #1;
    mon_en    = 1'b0;
    out_ready = 1'b0;

    // Back-pressure: credits stop admission after DEPTH launches
    repeat (2) @(posedge clk);
    #1;
    acc       = 0;
    in_valid  = 1'b1;
    in_negate = 1'b0;
    in_tag    = '0;
    stim_cos  = 32'h40000000;
    stim_sin  = 32'h40400000;
    repeat (20) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc++;
        in_tag   = in_tag + 1'b1;
        stim_cos = 32'h40000000 | 32'(acc);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_tag", 32'(out_tag), 32'(i));
      chk("bp_cos", out_cos, 32'h40000000 | 32'(i));
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
      end
    end
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset while three samples are in flight
    @(posedge clk);
    #1;
    launch_one(4'd7, 1'b0, 32'h3F800000, 32'h3F800000);
    launch_one(4'd8, 1'b0, 32'h3F800000, 32'h3F800000);
    launch_one(4'd9, 1'b0, 32'h3F800000, 32'h3F800000);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_ghosts", 32'(seen), 32'd0);

    // Recovery after reset
    @(posedge clk);
    #1;
    launch_one(4'd6, 1'b1, 32'h3F800000, 32'h40000000);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("recover_valid", 32'(out_valid), 32'd1);
    chk("recover_tag", 32'(out_tag), 32'd6);
    chk("recover_cos", out_cos, 32'hBF800000);
    chk("recover_sin", out_sin, 32'hC0000000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
